// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks the register file view port and streams every register over valid/ready.
// Define REG_DUMP_CHECKSUM_EN to append an XOR checksum word after the last register.
module reg_dump_reader #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     start,
  input  logic                     abort,
  output logic [ADDRESS_WIDTH-1:0] view_addr,
  input  logic [DATA_WIDTH-1:0]    view_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic [ADDRESS_WIDTH-1:0] out_index,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
);
`ifdef REG_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, SEND, CSUM, DONE} state_t;
  logic [DATA_WIDTH-1:0] acc;
`else
  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;
`endif
  localparam logic [ADDRESS_WIDTH-1:0] MAX = '1;
  state_t state;
  logic [ADDRESS_WIDTH-1:0] addr;
  assign view_addr = addr;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      addr <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_index <= '0;
      out_last <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      acc <= '0;
`endif
    end else if (abort) begin
      state <= IDLE;
      out_valid <= 1'b0;
      out_last <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          addr <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
          acc <= '0;
`endif
          state <= LOAD;
        end
        LOAD: begin
          out_data <= view_data;
          out_index <= addr;
          out_valid <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
          out_last <= 1'b0;
          acc <= acc ^ view_data;
`else
          out_last <= addr == MAX;
`endif
          state <= SEND;
        end
        SEND: if (out_ready) begin
          out_valid <= 1'b0;
          out_last <= 1'b0;
          addr <= addr == MAX ? addr : addr + 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
          state <= addr == MAX ? CSUM : LOAD;
`else
          state <= addr == MAX ? DONE : LOAD;
`endif
        end
`ifdef REG_DUMP_CHECKSUM_EN
        // first CSUM cycle loads the checksum word, later cycles wait for its handshake
        CSUM: if (!out_valid) begin
          out_data <= acc;
          out_index <= '0;
          out_last <= 1'b1;
          out_valid <= 1'b1;
        end else if (out_ready) begin
          out_valid <= 1'b0;
          out_last <= 1'b0;
          state <= DONE;
        end
`endif
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_dump_reader.sv
// tb_reg_dump_reader: table-driven and sequence checks of reg_dump_reader against a register file model.
module tb_reg_dump_reader;
  localparam int N = 32;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam int WORDS = N + 1;
`else
  localparam int WORDS = N;
`endif
  logic CLK = 1'b0, RST_N = 1'b0, start = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic [4:0] view_addr, out_index;
  logic [31:0] view_data, out_data;
  logic out_valid, out_last, busy, done;
  logic [31:0] regs [N];
  logic [31:0] expv [N];
  int checks = 0, errors = 0, stall_cnt = 0;
  typedef struct {
    logic [5:0]  ctl;
    logic [4:0]  idx;
    logic [31:0] data;
  } vec_t;
  vec_t tbl [14];
  always #5 CLK = ~CLK;
  assign view_data = regs[view_addr];
  reg_dump_reader dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .abort(abort),
    .view_addr(view_addr), .view_data(view_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .busy(busy), .done(done)
  );
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic dump(input int mode, output int n, output int first_v, output int done_cyc);
    logic [31:0] sum;
    sum = '0;
    n = 0;
    first_v = -1;
    done_cyc = -1;
    stall_cnt = 0;
    for (int i = 0; i < N; i++) sum ^= expv[i];
    start = 1'b1;
    out_ready = 1'b1;
    step();
    start = 1'b0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (out_valid && first_v < 0) first_v = cyc;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (mode == 0) start = cyc == 10;
      if (mode == 1) begin
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_index == 5'd1) regs[3] = 32'hDEADBEEF;
      end
      if (mode == 2) begin
        out_ready = !(out_valid && out_index == 5'd5 && stall_cnt < 10);
        if (!out_ready) begin
          stall_cnt++;
          chk("stall_idx", 32'(out_index), 32'd5);
          chk("stall_data", out_data, 32'h1000_0005);
        end
      end
      if (out_valid && out_ready) begin
        chk("word_idx", 32'(out_index), n < N ? n : 0);
        chk("word_data", out_data, n < N ? expv[n] : sum);
        chk("word_last", 32'(out_last), 32'(n == WORDS - 1));
        n++;
      end
      step();
    end
    chk("done_seen", 32'(done_cyc >= 0), 32'd1);
    chk("word_count", n, WORDS);
    // start during DONE must not launch another dump
    start = 1'b1;
    step();
    start = 1'b0;
    chk("post_done_low", 32'(done), 32'd0);
    step();
    chk("post_done_idle", 32'(busy), 32'd0);
  endtask
  initial begin
    int n, fv, dc;
    bit hit;
    for (int i = 0; i < N; i++) regs[i] = i == 0 ? 32'h0 : 32'h1000_0000 + i;
    tbl[0]  = '{6'b100010, 5'd0, 32'h0};
    tbl[1]  = '{6'b000110, 5'd0, 32'h0};
    tbl[2]  = '{6'b000110, 5'd0, 32'h0};
    tbl[3]  = '{6'b001010, 5'd0, 32'h0};
    tbl[4]  = '{6'b001110, 5'd1, 32'h1000_0001};
    tbl[5]  = '{6'b001010, 5'd1, 32'h1000_0001};
    tbl[6]  = '{6'b000110, 5'd2, 32'h1000_0002};
    tbl[7]  = '{6'b001010, 5'd2, 32'h1000_0002};
    tbl[8]  = '{6'b101110, 5'd3, 32'h1000_0003};
    tbl[9]  = '{6'b010000, 5'd3, 32'h1000_0003};
    tbl[10] = '{6'b110000, 5'd3, 32'h1000_0003};
    tbl[11] = '{6'b100010, 5'd3, 32'h1000_0003};
    tbl[12] = '{6'b001110, 5'd0, 32'h0};
    tbl[13] = '{6'b011000, 5'd0, 32'h0};
    step();
    step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_view", 32'(view_addr), 32'd0);
    chk("rst_data", out_data, 32'd0);
    RST_N = 1'b1;
    for (int i = 0; i < 14; i++) begin
      {start, abort, out_ready} = tbl[i].ctl[5:3];
      step();
      chk($sformatf("t%0d_valid", i), 32'(out_valid), 32'(tbl[i].ctl[2]));
      chk($sformatf("t%0d_busy", i), 32'(busy), 32'(tbl[i].ctl[1]));
      chk($sformatf("t%0d_done", i), 32'(done), 32'(tbl[i].ctl[0]));
      chk($sformatf("t%0d_idx", i), 32'(out_index), 32'(tbl[i].idx));
      chk($sformatf("t%0d_data", i), out_data, tbl[i].data);
    end
    {start, abort, out_ready} = 3'b000;
    step();
    for (int i = 0; i < N; i++) expv[i] = regs[i];
    dump(0, n, fv, dc);
    chk("first_valid_cyc", fv, 1);
    chk("done_cyc", dc, 2 * WORDS);
    expv[3] = 32'hDEADBEEF;
    dump(1, n, fv, dc);
    regs[3] = 32'h1000_0003;
    expv[3] = 32'h1000_0003;
    dump(2, n, fv, dc);
    chk("stall_cycles", stall_cnt, 10);
    start = 1'b1;
    out_ready = 1'b1;
    step();
    start = 1'b0;
    hit = 1'b0;
    for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
      hit = out_valid && out_index == 5'd12;
      if (!hit) step();
    end
    chk("reach_idx12", 32'(hit), 32'd1);
    #1 RST_N = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data", out_data, 32'd0);
    chk("arst_idx", 32'(out_index), 32'd0);
    chk("arst_last", 32'(out_last), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_view", 32'(view_addr), 32'd0);
    step();
    RST_N = 1'b1;
    step();
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_done", 32'(done), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
